// File: rtl/sram_key_reader.sv
// Reads logistic-map samples back from a 16-bit SRAM, folds each 32-bit sample
// into a key byte and hands key bytes out through a 4-entry valid/ready FIFO.
module sram_key_reader #(
    parameter int          NUM_SAMPLES = 25600,
    parameter logic [17:0] BASE_ADDR   = 18'd1,
    parameter int          RD_WAIT     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] databus_in,
    output logic [17:0] addressbus,
    output logic        ce,
    output logic        oe,
    output logic        we,
    output logic        lsb,
    output logic        msb,
    output logic [7:0]  key_byte,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] sample_out,
    output logic [2:0]  dbg_state
);
    localparam int CNT_W  = $clog2(NUM_SAMPLES + 1);
    localparam int WAIT_W = $clog2(RD_WAIT) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_PUSH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [15:0]        lo;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   sample_cnt;
    logic [7:0]         fifo_mem [4];
    logic [1:0]         wr_ptr;
    logic [1:0]         rd_ptr;
    logic [2:0]         fifo_count;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;
    logic [7:0]         new_key;

    assign we        = 1'b1;
    assign lsb       = 1'b0;
    assign msb       = 1'b0;
    assign dbg_state = state;

    // Handshake: a key transfers on every rising edge where key_valid and
    // key_ready are both high; key_byte holds steady until that transfer.
    assign key_valid = (fifo_count != 3'd0);
    assign key_byte  = fifo_mem[rd_ptr];
    assign fifo_full = (fifo_count == 3'd4);
    assign fifo_pop  = key_valid & key_ready;
    assign fifo_push = (state == S_PUSH) && !fifo_full;
    assign new_key   = sample_out[22:15] ^ sample_out[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            addressbus <= 18'd0;
            ce         <= 1'b1;
            oe         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_out <= 32'd0;
            lo         <= 16'd0;
            wait_cnt   <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RD_LO;
                        addressbus <= BASE_ADDR;
                        sample_cnt <= '0;
                        wait_cnt   <= '0;
                        ce         <= 1'b0;
                        oe         <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                S_RD_LO: begin
                    if (wait_cnt == WAIT_W'(RD_WAIT - 1)) begin
                        lo         <= databus_in;
                        addressbus <= addressbus + 18'd1;
                        wait_cnt   <= '0;
                        state      <= S_RD_HI;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_RD_HI: begin
                    if (wait_cnt == WAIT_W'(RD_WAIT - 1)) begin
                        sample_out <= {databus_in, lo};
                        addressbus <= addressbus + 18'd1;
                        wait_cnt   <= '0;
                        ce         <= 1'b1;
                        oe         <= 1'b1;
                        state      <= S_PUSH;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_PUSH: begin
                    // Full comes from the registered count, so a pop this cycle
                    // only lets the push through on the following edge.
                    if (!fifo_full) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (sample_cnt == CNT_W'(NUM_SAMPLES - 1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            ce    <= 1'b0;
                            oe    <= 1'b0;
                            state <= S_RD_LO;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= new_key;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + 2'd1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_key_reader.sv
// Bench for sram_key_reader: a single-sample instance driven from a vector table
// and an 8-sample instance run against a queue-based key model.
module tb_sram_key_reader;
    localparam int BASE = 1;
    localparam int N8   = 8;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [31:0] sample;
        logic [7:0]  key;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst1, rst8, start1, start8, ready1, ready8;
    logic [15:0] sram [64];
    logic [15:0] data1, data8;
    logic [17:0] addr1, addr8;
    logic        ce1, oe1, we1, lsb1, msb1, ce8, oe8, we8, lsb8, msb8;
    logic [7:0]  key1, key8;
    logic        valid1, valid8, busy1, busy8, done1, done8;
    logic [31:0] sample1, sample8;
    logic [2:0]  st1, st8;

    int          n_cmp, n_fail, got, last_addr;
    bit          rand_en;
    logic [7:0]  exp_q [$];
    vec_t        vecs [6];

    assign data1 = sram[addr1[5:0]];
    assign data8 = sram[addr8[5:0]];

    always #5 clk = ~clk;

    sram_key_reader #(.NUM_SAMPLES(1)) u_one (
        .clk(clk), .reset(rst1), .start(start1), .databus_in(data1),
        .addressbus(addr1), .ce(ce1), .oe(oe1), .we(we1), .lsb(lsb1), .msb(msb1),
        .key_byte(key1), .key_valid(valid1), .key_ready(ready1),
        .busy(busy1), .done(done1), .sample_out(sample1), .dbg_state(st1)
    );

    sram_key_reader #(.NUM_SAMPLES(N8)) u_eight (
        .clk(clk), .reset(rst8), .start(start8), .databus_in(data8),
        .addressbus(addr8), .ce(ce8), .oe(oe8), .we(we8), .lsb(lsb8), .msb(msb8),
        .key_byte(key8), .key_valid(valid8), .key_ready(ready8),
        .busy(busy8), .done(done8), .sample_out(sample8), .dbg_state(st8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_sample(input int i);
        return {sram[BASE + 2*i + 1], sram[BASE + 2*i]};
    endfunction

    function automatic logic [7:0] model_key(input int i);
        logic [31:0] s;
        s = model_sample(i);
        return 8'(((s >> 15) ^ s) & 32'hFF);
    endfunction

    // Observe at the negedge (inputs for the next edge already applied), then advance one cycle.
    task automatic step8();
        if (valid8 && ready8) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_extra: got key %h expected no key", key8);
            end else begin
                check("sb_key", key8, exp_q.pop_front());
            end
            got++;
        end
        if (!ce8 && addr8 != last_addr[17:0]) begin
            check("addr_incr", addr8, last_addr + 1);
            last_addr = addr8;
        end
        @(posedge clk);
        @(negedge clk);
        if (rand_en) ready8 = 1'($urandom_range(0, 1));
    endtask

    task automatic fill_random();
        for (int a = 1; a <= 2*N8; a++) sram[a] = 16'($urandom);
    endtask

    task automatic run8_start();
        exp_q.delete();
        for (int i = 0; i < N8; i++) exp_q.push_back(model_key(i));
        got = 0;
        last_addr = 0;
        start8 = 1'b1;
        step8();
        start8 = 1'b0;
    endtask

    task automatic finish8(input string tag);
        for (int k = 0; k < 2000 && !(done8 && !valid8); k++) step8();
        check({tag, "_done"}, done8, 1'b1);
        check({tag, "_busy"}, busy8, 1'b0);
        check({tag, "_keys"}, got, N8);
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_last_addr"}, last_addr, BASE + 2*N8 - 1);
        check({tag, "_sample"}, sample8, model_sample(N8 - 1));
    endtask

    task automatic check_reset8(input string tag);
        check({tag, "_addr"}, addr8, 18'd0);
        check({tag, "_strobes"}, {ce8, oe8, we8, lsb8, msb8}, 5'b11100);
        check({tag, "_valid"}, valid8, 1'b0);
        check({tag, "_key"}, key8, 8'd0);
        check({tag, "_busy_done"}, {busy8, done8}, 2'b00);
        check({tag, "_sample"}, sample8, 32'd0);
        check({tag, "_state"}, st8, 3'd0);
    endtask

    // c counts cycles after the edge that samples start; done shows up on c=6.
    task automatic run_single(input vec_t v, input int idx);
        logic [17:0] ea;
        sram[1] = v.lo;
        sram[2] = v.hi;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            ea = (c <= 2) ? 18'd1 : (c <= 4) ? 18'd2 : 18'd3;
            check($sformatf("v%0d_c%0d_addr", idx, c), addr1, ea);
            check($sformatf("v%0d_c%0d_ce_oe", idx, c), {ce1, oe1}, (c <= 4) ? 2'b00 : 2'b11);
            check($sformatf("v%0d_c%0d_busy", idx, c), busy1, c <= 5);
            check($sformatf("v%0d_c%0d_done", idx, c), done1, c >= 6);
            check($sformatf("v%0d_c%0d_valid", idx, c), valid1, c == 6);
            if (c >= 5) check($sformatf("v%0d_sample", idx), sample1, v.sample);
            if (c == 6) check($sformatf("v%0d_key", idx), key1, v.key);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{lo: 16'hE148, hi: 16'h3E7A, sample: 32'h3E7AE148, key: 8'hBD};
        vecs[1] = '{lo: 16'hCCCD, hi: 16'h3DCC, sample: 32'h3DCCCCCD, key: 8'h54};
        vecs[2] = '{lo: 16'h0000, hi: 16'h0000, sample: 32'h00000000, key: 8'h00};
        vecs[3] = '{lo: 16'hFFFF, hi: 16'hFFFF, sample: 32'hFFFFFFFF, key: 8'h00};
        vecs[4] = '{lo: 16'h0000, hi: 16'h0040, sample: 32'h00400000, key: 8'h80};
        vecs[5] = '{lo: 16'h80FF, hi: 16'h0000, sample: 32'h000080FF, key: 8'hFE};

        n_cmp = 0; n_fail = 0; got = 0; last_addr = 0; rand_en = 1'b0;
        rst1 = 1'b1; rst8 = 1'b1; start1 = 1'b0; start8 = 1'b0;
        ready1 = 1'b1; ready8 = 1'b0;
        for (int a = 0; a < 64; a++) sram[a] = 16'd0;

        #1;
        check_reset8("rst8");
        check("rst1_addr", addr1, 18'd0);
        check("rst1_strobes", {ce1, oe1, we1, lsb1, msb1}, 5'b11100);
        check("rst1_outs", {valid1, busy1, done1}, 3'b000);
        check("rst1_key_sample", {key1, sample1}, 40'd0);
        check("rst1_state", st1, 3'd0);
        @(negedge clk);
        rst1 = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_single(vecs[i], i);

        // Random SRAM contents with random consumer backpressure.
        rand_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            fill_random();
            run8_start();
            finish8($sformatf("rand%0d", t));
        end
        rand_en = 1'b0;
        ready8 = 1'b0;

        // Full FIFO stalls the fifth sample in PUSH.
        fill_random();
        run8_start();
        for (int k = 0; k < 40; k++) step8();
        check("bp_strobes", {ce8, oe8}, 2'b11);
        check("bp_addr", addr8, BASE + 2*(4 + 1));
        check("bp_valid", valid8, 1'b1);
        check("bp_head", key8, model_key(0));
        check("bp_done", done8, 1'b0);
        for (int k = 0; k < 3; k++) step8();
        check("bp_addr_hold", addr8, BASE + 2*(4 + 1));
        check("bp_head_hold", key8, model_key(0));
        ready8 = 1'b1;
        step8();
        ready8 = 1'b0;
        check("pp_still_push", {ce8, oe8}, 2'b11);
        check("pp_head_next", key8, model_key(1));
        step8();
        check("pp_pushed_ce", ce8, 1'b0);
        check("pp_pushed_addr", addr8, BASE + 2*(4 + 1));
        for (int k = 0; k < 10; k++) step8();
        check("bp2_addr", addr8, BASE + 2*(4 + 2));
        check("bp2_strobes", {ce8, oe8}, 2'b11);
        ready8 = 1'b1;
        finish8("bp");

        // Reset in RD_HI of sample 3, then a restart with a start pulse during sample 2.
        fill_random();
        run8_start();
        for (int k = 0; k < 200 && !(addr8 == 18'd6 && !ce8); k++) step8();
        check("mid_reach_rd_hi3", {addr8, ce8}, {18'd6, 1'b0});
        #2 rst8 = 1'b1;
        #1 check_reset8("mid_rst");
        exp_q.delete();
        @(negedge clk);
        rst8 = 1'b0;
        fill_random();
        run8_start();
        check("restart_addr", addr8, 18'd1);
        check("restart_ce", ce8, 1'b0);
        for (int k = 0; k < 200 && !(addr8 == 18'd3 && !ce8); k++) step8();
        check("ign_reach_rd_lo2", {addr8, ce8}, {18'd3, 1'b0});
        start8 = 1'b1;
        step8();
        start8 = 1'b0;
        finish8("ign");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
